snes_gsu_mem_arb: RTL

SNES_GSU_MEM_ARB -- requirements
Module: snes_gsu_mem_arb

---
 rtl/snes_gsu_mem_arb_pkg.sv | 11 +
 rtl/snes_gsu_addr_decode.sv | 25 ++
 rtl/snes_gsu_mem_arb.sv | 138 +++++++++++++
 3 files changed

// File: rtl/snes_gsu_mem_arb_pkg.sv
// snes_gsu_mem_arb_pkg: shared FSM/address-class types and SNES memory-map constants
package snes_gsu_mem_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ACCESS, S_DONE} state_e;
  typedef enum logic [1:0] {CLS_ROM, CLS_SRAM, CLS_NONE} cls_e;
  localparam logic [23:0] SRAM_BASE    = 24'hE00000;
  localparam logic [7:0]  ROM_LO_LAST  = 8'h3F;
  localparam logic [7:0]  ROM_HI_FIRST = 8'h40;
  localparam logic [7:0]  ROM_HI_LAST  = 8'h5F;
  localparam logic [7:0]  SRAM_BANK_LO = 8'h70;
  localparam logic [7:0]  SRAM_BANK_HI = 8'h78;
endpackage

// File: rtl/snes_gsu_addr_decode.sv
// snes_gsu_addr_decode: classifies a SNES address as ROM/SaveRAM/unmapped and translates it to an SRAM address
module snes_gsu_addr_decode
  import snes_gsu_mem_arb_pkg::*;
(
  input  logic [23:0] addr_i,
  input  logic [23:0] rom_mask_i,
  input  logic [23:0] saveram_mask_i,
  output cls_e        cls_o,
  output logic [23:0] addr_o
);
  logic [7:0] bank;
  logic is_rom_lo, is_rom_hi, is_sram;
  assign bank      = addr_i[23:16];
  assign is_rom_lo = bank <= ROM_LO_LAST && addr_i[15];
  assign is_rom_hi = bank >= ROM_HI_FIRST && bank <= ROM_HI_LAST;
  // SaveRAM occupies bank pairs 70-71 and 78-79, and only exists when a nonzero mask is configured
  assign is_sram   = (bank[7:1] == SRAM_BANK_LO[7:1] || bank[7:1] == SRAM_BANK_HI[7:1]) && |saveram_mask_i;
  // class and translated address; unmapped addresses translate to zero
  always_comb begin
    cls_o  = (is_rom_lo || is_rom_hi) ? CLS_ROM : is_sram ? CLS_SRAM : CLS_NONE;
    addr_o = is_rom_lo ? ({3'b0, addr_i[21:16], addr_i[14:0]} & rom_mask_i) :
             is_rom_hi ? ({3'b0, addr_i[20:0]} & rom_mask_i) :
             is_sram   ? (SRAM_BASE | ({7'b0, addr_i[16:0]} & saveram_mask_i)) : '0;
  end
endmodule

// File: rtl/snes_gsu_mem_arb.sv
// snes_gsu_mem_arb: round-robin SNES/GSU arbiter for a shared SRAM; define SNES_PRIO_EN to give channel 0 absolute priority
module snes_gsu_mem_arb
  import snes_gsu_mem_arb_pkg::*;
#(
  parameter int          N_CH     = 2,
  parameter int          MEM_WAIT = 3,
  parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N_CH-1:0]      REQ,
  input  logic [N_CH-1:0]      WE,
  input  logic [24*N_CH-1:0]   ADDR,
  input  logic [8*N_CH-1:0]    WDATA,
  output logic [N_CH-1:0]      ACK,
  output logic [7:0]           RDATA,
  input  logic [23:0]          SAVERAM_MASK,
  input  logic [23:0]          ROM_MASK,
  output logic [23:0]          MEM_ADDR,
  output logic                 MEM_OE,
  output logic                 MEM_WE,
  output logic [7:0]           MEM_WDATA,
  input  logic [7:0]           MEM_RDATA,
  output logic                 BUSY
);
  localparam int IW = N_CH > 1 ? $clog2(N_CH) : 1;
  state_e            state_q, state_d;
  cls_e              cls_q, dec_cls;
  logic [IW-1:0]     ptr_q, ptr_d, win_q, gnt_idx;
  logic              gnt_ok, accept, we_q;
  logic [23:0]       req_addr_q, dec_addr, maddr_q;
  logic [7:0]        wdata_q, rdata_q;
  logic [3:0]        cnt_q;
  logic [N_CH-1:0]   ack_q;
  int                rr_j;

  snes_gsu_addr_decode u_dec (
    .addr_i         (req_addr_q),
    .rom_mask_i     (ROM_MASK),
    .saveram_mask_i (SAVERAM_MASK),
    .cls_o          (dec_cls),
    .addr_o         (dec_addr)
  );

  // round-robin pick: scan downward so the lowest channel at or after the pointer wins last
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    rr_j    = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      rr_j = int'(ptr_q) + k;
      rr_j = rr_j >= N_CH ? rr_j - N_CH : rr_j;
`ifdef SNES_PRIO_EN
      if (REQ[rr_j] && rr_j != 0) begin
`else
      if (REQ[rr_j]) begin
`endif
        gnt_ok  = 1'b1;
        gnt_idx = IW'(rr_j);
      end
    end
`ifdef SNES_PRIO_EN
    if (REQ[0]) begin
      gnt_ok  = 1'b1;
      gnt_idx = '0;
    end
`endif
    ptr_d = gnt_idx == IW'(N_CH - 1) ? '0 : gnt_idx + 1'b1;
  end

  // the cycle carrying ACK is not an arbitration slot, so a held REQ re-arbitrates one cycle later
  assign accept = state_q == S_IDLE && gnt_ok && !(|ack_q);

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: unmapped accesses skip ACCESS entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = accept ? S_DECODE : S_IDLE;
      S_DECODE: state_d = dec_cls == CLS_NONE ? S_DONE : S_ACCESS;
      S_ACCESS: state_d = cnt_q == 4'd0 ? S_DONE : S_ACCESS;
      default:  state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ROM writes run the access window with no write strobe
  always_comb begin
    MEM_OE = state_q == S_ACCESS && !we_q;
    MEM_WE = state_q == S_ACCESS && we_q && cls_q == CLS_SRAM;
    BUSY   = state_q != S_IDLE;
  end

  // transaction datapath: latch request, register decode, count wait states, capture data, pulse ACK
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q      <= '0;
      win_q      <= '0;
      req_addr_q <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cls_q      <= CLS_NONE;
      maddr_q    <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      ack_q      <= '0;
    end else begin
      ack_q <= '0;
      if (accept) begin
        win_q      <= gnt_idx;
        req_addr_q <= ADDR[24*gnt_idx +: 24];
        we_q       <= WE[gnt_idx];
        wdata_q    <= WDATA[8*gnt_idx +: 8];
        ptr_q      <= ptr_d;
      end
      if (state_q == S_DECODE) begin
        cls_q   <= dec_cls;
        maddr_q <= dec_addr;
        cnt_q   <= 4'(MEM_WAIT - 1);
        if (dec_cls == CLS_NONE) rdata_q <= OPEN_BUS;
      end
      if (state_q == S_ACCESS) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd0 && !we_q) rdata_q <= MEM_RDATA;
      end
      if (state_q == S_DONE) ack_q[win_q] <= 1'b1;
    end
  end

  assign ACK       = ack_q;
  assign RDATA     = rdata_q;
  assign MEM_ADDR  = maddr_q;
  assign MEM_WDATA = wdata_q;
endmodule
